// File: rtl/sys_seq_ctrl_if.sv
// Operand-memory, array-top and job-control signals of the systolic sequencer.
// slave is the sequencer side; master is the memory/array/host side.
interface sys_seq_ctrl_if #(
    parameter int ARRAY_H = 4,
    parameter int ARRAY_W = 4,
    parameter int DATA_W  = 8,
    parameter int OUT_W   = 32
);
    localparam int AW = $clog2(2 * ARRAY_H);

    logic                        start;
    logic                        reuse_w;
    logic                        busy;
    logic                        done;
    logic                        rd_en;
    logic [AW-1:0]               rd_addr;
    logic [DATA_W*ARRAY_W-1:0]   rd_data;
    logic [DATA_W*ARRAY_W-1:0]   in_weight;
    logic [DATA_W*ARRAY_W-1:0]   in_act;
    logic                        weight_buffer_load_en;
    logic                        weight_buffer_out_en;
    logic                        write_weight_en;
    logic                        input_buffer_load_en;
    logic                        input_buffer_out_en;
    logic                        output_buffer_load_en;
    logic                        output_buffer_out_en;
    logic [OUT_W*ARRAY_W-1:0]    out_res;
    logic                        res_valid;
    logic [OUT_W*ARRAY_W-1:0]    res_data;

    modport slave (
        input  start, reuse_w, rd_data, out_res,
        output busy, done, rd_en, rd_addr, in_weight, in_act,
               weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
               input_buffer_load_en, input_buffer_out_en,
               output_buffer_load_en, output_buffer_out_en,
               res_valid, res_data
    );

    modport master (
        output start, reuse_w, rd_data, out_res,
        input  busy, done, rd_en, rd_addr, in_weight, in_act,
               weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
               input_buffer_load_en, input_buffer_out_en,
               output_buffer_load_en, output_buffer_out_en,
               res_valid, res_data
    );
endinterface

// File: rtl/sys_seq_ctrl.sv
// Systolic array job sequencer: streams weight/activation rows from operand memory and times
// the array-top buffer strobes. Define SYS_SEQ_WREUSE_EN to let reuse_w skip the weight load.
module sys_seq_ctrl #(
    parameter int ARRAY_H   = 4,
    parameter int ARRAY_W   = 4,
    parameter int DATA_W    = 8,
    parameter int OUT_W     = 32,
    parameter int DSP_DELAY = 1
) (
    input logic           clk,
    input logic           rst,
    sys_seq_ctrl_if.slave bus
);
    localparam int AW        = $clog2(2 * ARRAY_H);
    localparam int ROW_W     = DATA_W * ARRAY_W;
    localparam int RES_W     = OUT_W * ARRAY_W;
    localparam int FILL_LEN  = DSP_DELAY * (ARRAY_W - 1);
    localparam int DRAIN_LEN = 2 * DSP_DELAY * ARRAY_H;
    localparam int MAX_A     = (DRAIN_LEN > ARRAY_H) ? DRAIN_LEN : ARRAY_H;
    localparam int CNT_MAX   = (MAX_A > FILL_LEN) ? MAX_A : FILL_LEN;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] H_LAST     = CW'(ARRAY_H - 1);
    localparam logic [CW-1:0] FILL_LAST  = CW'((FILL_LEN > 0) ? FILL_LEN - 1 : 0);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_LEN - 1);

    typedef enum logic [2:0] {IDLE, WLOAD, ALOAD, FILL, DRAIN, READ, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic              wbuf_load_q, wbuf_load_d;
    logic              act_win_q, act_win_d;
    logic              ibuf_out_q, ibuf_out_d;
    logic              obuf_load_q, obuf_load_d;
    logic              obuf_out_q, obuf_out_d;
    logic              res_valid_q, res_valid_d;
    logic [RES_W-1:0]  res_data_q, res_data_d;
    logic              reuse_eff;

`ifdef SYS_SEQ_WREUSE_EN
    assign reuse_eff = bus.reuse_w;
`else
    assign reuse_eff = 1'b0;
`endif

    // Reads are issued from the next state so the address leaves a flop in the read cycle;
    // strobes are derived from the current state so they land one cycle later, with rd_data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start) state_d = reuse_eff ? ALOAD : WLOAD;
            end
            WLOAD: if (cnt_q == H_LAST) begin
                cnt_d   = '0;
                state_d = ALOAD;
            end
            ALOAD: if (cnt_q == H_LAST) begin
                cnt_d   = '0;
                state_d = (FILL_LEN > 0) ? FILL : DRAIN;
            end
            FILL: if (cnt_q == FILL_LAST) begin
                cnt_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: if (cnt_q == DRAIN_LAST) begin
                cnt_d   = '0;
                state_d = READ;
            end
            READ: if (cnt_q == H_LAST) begin
                cnt_d   = '0;
                state_d = DONE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d != IDLE) || (state_q == DONE);
        rd_en_d   = (state_d == WLOAD) || (state_d == ALOAD);
        rd_addr_d = '0;
        if (state_d == WLOAD) rd_addr_d = AW'(cnt_d);
        if (state_d == ALOAD) rd_addr_d = AW'(ARRAY_H) + AW'(cnt_d);

        wbuf_load_d = (state_q == WLOAD);
        act_win_d   = (state_q == ALOAD);
        ibuf_out_d  = (state_q == FILL) || (state_q == DRAIN) || (state_q == READ);
        obuf_load_d = (state_q == DRAIN);
        obuf_out_d  = (state_q == READ);
        done_d      = (state_q == DONE);
        res_valid_d = obuf_out_q;
        res_data_d  = obuf_out_q ? bus.out_res : res_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            wbuf_load_q <= 1'b0;
            act_win_q   <= 1'b0;
            ibuf_out_q  <= 1'b0;
            obuf_load_q <= 1'b0;
            obuf_out_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            wbuf_load_q <= wbuf_load_d;
            act_win_q   <= act_win_d;
            ibuf_out_q  <= ibuf_out_d;
            obuf_load_q <= obuf_load_d;
            obuf_out_q  <= obuf_out_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.busy                  = busy_q;
    assign bus.done                  = done_q;
    assign bus.rd_en                 = rd_en_q;
    assign bus.rd_addr               = rd_addr_q;
    // Operand rows pass straight through, gated by the flopped windows that align with rd_data.
    assign bus.in_weight             = wbuf_load_q ? bus.rd_data : {ROW_W{1'b0}};
    assign bus.in_act                = act_win_q ? bus.rd_data : {ROW_W{1'b0}};
    assign bus.weight_buffer_load_en = wbuf_load_q;
    assign bus.weight_buffer_out_en  = act_win_q;
    assign bus.write_weight_en       = act_win_q;
    assign bus.input_buffer_load_en  = act_win_q;
    assign bus.input_buffer_out_en   = ibuf_out_q;
    assign bus.output_buffer_load_en = obuf_load_q;
    assign bus.output_buffer_out_en  = obuf_out_q;
    assign bus.res_valid             = res_valid_q;
    assign bus.res_data              = res_data_q;
endmodule

// File: tb/tb_sys_seq_ctrl.sv
// Scoreboard bench for sys_seq_ctrl at H=W=4, D=1: stimulus queues expected strobe/result
// events per job, a negedge monitor pops and compares them as the DUT produces them.
module tb_sys_seq_ctrl;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int DW = 8;
    localparam int OW = 32;
    localparam int NCH = 10;
    localparam int BIG = 1000000;
`ifdef SYS_SEQ_WREUSE_EN
    localparam bit WREUSE = 1'b1;
`else
    localparam bit WREUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sys_seq_ctrl_if #(.ARRAY_H(H), .ARRAY_W(W), .DATA_W(DW), .OUT_W(OW)) bus ();
    sys_seq_ctrl #(.ARRAY_H(H), .ARRAY_W(W), .DATA_W(DW), .OUT_W(OW), .DSP_DELAY(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memv(int a);
        case (a % 4)
            0:       return 32'h04030201;
            1:       return 32'h08070605;
            2:       return 32'h0c0b0a09;
            default: return 32'h100f0e0d;
        endcase
    endfunction

    function automatic logic [127:0] pat(int k);
        logic [31:0] v;
        v = 32'hA5000000 | 32'(k);
        return {v, v, v, v};
    endfunction

    always @(posedge clk) if (bus.rd_en) bus.rd_data <= memv(int'(bus.rd_addr));
    assign bus.out_res = pat(cyc);

    typedef struct { int c; logic [127:0] d; } evt_t;
    evt_t  q [NCH][$];
    string nm [NCH] = '{"rd", "wload", "iload", "iout", "oload", "oout", "res", "done",
                        "wwrite", "wbout"};
    int bz_lo[$];
    int bz_hi[$];
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic ev(int ch, int c, logic [127:0] d, int cut);
        if (c <= cut) q[ch].push_back('{c: c, d: d});
    endtask

    // Hand-derived schedule relative to T0 (virtual T0 = S-2 when the weight load is skipped).
    task automatic push_job(int s, bit reuse, int cut);
        bit skip;
        int t0;
        skip = reuse & WREUSE;
        t0   = skip ? s - 2 : s + 2;
        for (int i = 0; i < 4; i++) begin
            if (!skip) ev(0, t0 - 1 + i, 128'(i), cut);
            if (!skip) ev(1, t0 + i, 128'(memv(i)), cut);
        end
        for (int i = 0; i < 4; i++) begin
            ev(0, t0 + 3 + i, 128'(4 + i), cut);
            ev(2, t0 + 4 + i, 128'(memv(4 + i)), cut);
            ev(8, t0 + 4 + i, '0, cut);
            ev(9, t0 + 4 + i, '0, cut);
        end
        for (int c = t0 + 8; c <= t0 + 22; c++) ev(3, c, '0, cut);
        for (int c = t0 + 11; c <= t0 + 18; c++) ev(4, c, '0, cut);
        for (int i = 0; i < 4; i++) begin
            ev(5, t0 + 19 + i, '0, cut);
            ev(6, t0 + 20 + i, pat(t0 + 19 + i), cut);
        end
        ev(7, t0 + 23, '0, cut);
        bz_lo.push_back(s + 1);
        bz_hi.push_back((t0 + 23 < cut) ? t0 + 23 : cut);
    endtask

    task automatic chk(int ch, logic pres, logic [127:0] d);
        evt_t e;
        if (pres === 1'b1) begin
            checks++;
            if (q[ch].size() == 0) begin
                errors++;
                $display("FAIL %s unexpected at cycle %0d data %h", nm[ch], cyc, d);
            end else begin
                e = q[ch].pop_front();
                if (e.c != cyc || e.d !== d) begin
                    errors++;
                    $display("FAIL %s got cycle %0d data %h, expected cycle %0d data %h",
                             nm[ch], cyc, d, e.c, e.d);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit eb;
            chk(0, bus.rd_en, 128'(bus.rd_addr));
            chk(1, bus.weight_buffer_load_en, 128'(bus.in_weight));
            chk(2, bus.input_buffer_load_en, 128'(bus.in_act));
            chk(3, bus.input_buffer_out_en, '0);
            chk(4, bus.output_buffer_load_en, '0);
            chk(5, bus.output_buffer_out_en, '0);
            chk(6, bus.res_valid, bus.res_data);
            chk(7, bus.done, '0);
            chk(8, bus.write_weight_en, '0);
            chk(9, bus.weight_buffer_out_en, '0);
            eb = 1'b0;
            foreach (bz_lo[i]) if (cyc >= bz_lo[i] && cyc <= bz_hi[i]) eb = 1'b1;
            checks++;
            if (bus.busy !== eb) begin
                errors++;
                $display("FAIL busy at cycle %0d got %b expected %b", cyc, bus.busy, eb);
            end
            checks++;
            if ((!bus.weight_buffer_load_en && bus.in_weight !== '0) ||
                (!bus.input_buffer_load_en && bus.in_act !== '0)) begin
                errors++;
                $display("FAIL row_zero at cycle %0d got in_weight %h in_act %h expected 0",
                         cyc, bus.in_weight, bus.in_act);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) tick();
    endtask

    task automatic cmp(string n, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, got, exp);
        end
    endtask

    task automatic check_all_zero(string tag);
        cmp({tag, "_busy"}, 128'(bus.busy), '0);
        cmp({tag, "_done"}, 128'(bus.done), '0);
        cmp({tag, "_rd"}, 128'({bus.rd_en, bus.rd_addr}), '0);
        cmp({tag, "_strobes"}, 128'({bus.weight_buffer_load_en, bus.weight_buffer_out_en,
            bus.write_weight_en, bus.input_buffer_load_en, bus.input_buffer_out_en,
            bus.output_buffer_load_en, bus.output_buffer_out_en}), '0);
        cmp({tag, "_rows"}, 128'({bus.in_weight, bus.in_act}), '0);
        cmp({tag, "_res_valid"}, 128'(bus.res_valid), '0);
        cmp({tag, "_res_data"}, bus.res_data, '0);
    endtask

    initial begin
        int s, s2, t0b, s3, s4;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.reuse_w = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Job A, with a start at T0+5 that must be ignored.
        s = 10;
        wait_cyc(s);
        bus.start = 1'b1;
        push_job(s, 1'b0, BIG);
        tick();
        bus.start = 1'b0;
        wait_cyc(s + 7);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;

        // Job B starts in A's done cycle (T0+23) with reuse_w set.
        s2 = s + 25;
        wait_cyc(s2);
        bus.start = 1'b1;
        bus.reuse_w = 1'b1;
        push_job(s2, 1'b1, BIG);
        tick();
        bus.start = 1'b0;
        bus.reuse_w = 1'b0;
        // A start one cycle before done is not accepted.
        t0b = (WREUSE) ? s2 - 2 : s2 + 2;
        wait_cyc(t0b + 22);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;

        // Job C aborted by reset at T0+12.
        s3 = t0b + 30;
        wait_cyc(s3);
        bus.start = 1'b1;
        push_job(s3, 1'b0, s3 + 14);
        tick();
        bus.start = 1'b0;
        wait_cyc(s3 + 14);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("abort");

        // Job D confirms a clean restart after the abort.
        s4 = s3 + 40;
        wait_cyc(s4);
        bus.start = 1'b1;
        push_job(s4, 1'b0, BIG);
        tick();
        bus.start = 1'b0;
        wait_cyc(s4 + 40);

        for (int ch = 0; ch < NCH; ch++) begin
            checks++;
            if (q[ch].size() != 0) begin
                errors++;
                $display("FAIL %s missing %0d events, first expected at cycle %0d",
                         nm[ch], q[ch].size(), q[ch][0].c);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sys_seq_ctrl.md
SYS_SEQ_CTRL -- requirements
Module: sys_seq_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_H, 4, systolic array rows; this is the row count per operand block.
REQ-002 SHALL have parameter ARRAY_W, 4, systolic array columns.
REQ-003 SHALL have parameter DATA_W, 8, operand element width.
REQ-004 SHALL have parameter OUT_W, 32, result element width.
REQ-005 SHALL have parameter DSP_DELAY, 1, per-PE pipeline delay in cycles.
REQ-006 SHALL have port clk, input, 1, clock; reset is rst, synchronous, active-high.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, job request pulse.
REQ-009 SHALL have port reuse_w, input, 1, skip weight load; sampled with start.
REQ-010 SHALL have port busy, output, 1, job in progress.
REQ-011 SHALL have port done, output, 1, one-cycle job-complete pulse.
REQ-012 SHALL have port rd_en, output, 1, operand memory read strobe.
REQ-013 SHALL have port rd_addr, output, clog2(2*ARRAY_H), operand row address.
REQ-014 SHALL have port rd_data, input, DATA_W*ARRAY_W, operand row; valid 1 cycle after rd_en.
REQ-015 SHALL have ports in_weight and in_act, output, DATA_W*ARRAY_W, operand rows to array top.
REQ-016 SHALL have ports weight_buffer_load_en, weight_buffer_out_en, write_weight_en, input_buffer_load_en, input_buffer_out_en, output_buffer_load_en and output_buffer_out_en, each an output of width 1, forming the array top control strobes.
REQ-017 SHALL have port out_res, input, OUT_W*ARRAY_W, result row from array top.
REQ-018 SHALL have port res_valid, output, 1, result row valid.
REQ-019 SHALL have port res_data, output, OUT_W*ARRAY_W, captured result row.

Function
REQ-020 SHALL implement FSM states IDLE, WLOAD, ALOAD, FILL, DRAIN, READ, DONE.
REQ-021 SHALL accept start only in IDLE; start while busy is ignored; busy is high from the cycle after acceptance through the DONE cycle.
REQ-022 SHALL go from IDLE to WLOAD on accepted start, or to ALOAD when reuse_w is effective (REQ-035).
REQ-023 SHALL issue rd_en in WLOAD (ARRAY_H cycles, rd_addr 0..ARRAY_H-1) and ALOAD (ARRAY_H cycles, rd_addr ARRAY_H..2*ARRAY_H-1).
REQ-024 SHALL register all strobe outputs so that each strobe is aligned with rd_data, which arrives one cycle after its address.
REQ-025 SHALL define T0 as the first cycle of the aligned load window, and drive the strobes at schedule count c = cycle - T0 as follows:
- weight_buffer_load_en, in_weight=rd_data: c in [0,H)
- input_buffer_load_en, write_weight_en, weight_buffer_out_en, in_act=rd_data: c in [H,2H)
- input_buffer_out_en: c in [2H, END)
- output_buffer_load_en: c in [2H+D*(W-1), 2H+D*(W-1)+2DH)
- output_buffer_out_en: c in [2H+D*(W-1)+2DH, END), where END = 3H+D*(W-1)+2DH
REQ-026 SHALL drive in_weight and in_act to 0 outside their windows.
REQ-027 SHALL sequence FILL (D*(W-1) cycles, may be 0), then DRAIN (2DH cycles), then READ (H cycles), then DONE (1 cycle, done=1), then IDLE.
REQ-028 SHALL, on each edge following a cycle with output_buffer_out_en=1, load res_data from out_res and assert res_valid for that cycle, giving exactly ARRAY_H res_valid pulses per job.
REQ-029 SHALL hold res_data between pulses.
REQ-030 SHALL size phase counters to cover max(2DH, H, D*(W-1)) without wrap.
REQ-031 SHALL assert done exactly one cycle after the last res_valid-producing strobe window ends.
REQ-032 SHALL accept a start asserted in the DONE cycle, or later; a start asserted earlier is not accepted.

Reset
REQ-033 SHALL, on rst, synchronously force IDLE, busy=0, done=0, rd_en=0, rd_addr=0, all strobes=0, in_weight=0, in_act=0, res_valid=0, res_data=0, and clear counters.
REQ-034 SHALL give rst priority over start in the same cycle; rst mid-job aborts with no done and no further res_valid.

Configuration
REQ-035 SHALL gate weight reuse with macro SYS_SEQ_WREUSE_EN: when defined, start with reuse_w=1 skips WLOAD, T0 is taken as the virtual WLOAD start, and no weight_buffer_load_en or WLOAD reads occur while all other windows keep their count positions; when undefined, reuse_w is ignored and WLOAD always runs.

Verification (H=W=4, D=1, OUT_W=32, mem[0..7]=04030201,08070605,0c0b0a09,100f0e0d repeated)
REQ-036 SHALL cover basic job: start at cycle S gives T0=S+2, weight_buffer_load_en on T0..T0+3 with in_weight 04030201..100f0e0d, input_buffer_load_en on T0+4..T0+7, output_buffer_load_en on T0+11..T0+18, output_buffer_out_en on T0+19..T0+22, and done at T0+23.
REQ-037 SHALL cover result capture: out_res driven as a distinct value per cycle yields 4 res_valid pulses with res_data equal to out_res on T0+20..T0+23.
REQ-038 SHALL cover start while busy: a second start at T0+5 is ignored, with one done only; a start in the done cycle begins a new job with T0'=done+2.
REQ-039 SHALL cover reset mid-job: rst at T0+12 gives all outputs 0 the next cycle, no done, and busy=0.
REQ-040 SHALL cover weight reuse with SYS_SEQ_WREUSE_EN defined: start with reuse_w=1 gives no weight_buffer_load_en, first rd_addr=4, and input_buffer_load_en at T0+4..T0+7; with the macro undefined the schedule is identical to REQ-036.
